apu_frame_sequencer: RTL and testbench

Frame sequencer for the NES APU. It divides the system clock into quarter-frame step events and sequences the pulse channels. It produces the single-cycle `iEnvelope_clk` and `iLength_sweep_clk` strobes consumed by every rectangle, triangle and noise channel. It also implements the $4017 frame-control register (4-step/5-step mode, IRQ inhibit) and the frame IRQ flag. It sits in the APU top level between the CPU register decoder and the channel instances.

---
 rtl/apu_frame_sequencer.sv | 148 ++++++++++++++
 tb/tb_apu_frame_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_frame_sequencer.sv
// NES APU frame sequencer: quarter/half-frame strobes, $4017 control, frame IRQ.
// Optional frame IRQ (flag, inhibit bit, ack) is built when APU_FRAME_IRQ_EN is defined.
module apu_frame_sequencer #(
  parameter int DIVIDER = 7457
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iW_frame,
  input  logic [7:0] iFrame_data,
  input  logic       iIrq_ack,
  output logic       oEnvelope_clk,
  output logic       oLength_sweep_clk,
  output logic       oIrq,
  output logic [2:0] oStep,
  output logic       oMode
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } stepT;

  localparam logic [15:0] PRE_LAST = 16'(DIVIDER - 1);

  logic [15:0] pre;
  stepT        step;
  stepT        stepNext;
  logic        mode;
  logic        envClk;
  logic        lenClk;
  logic        envNext;
  logic        lenNext;
  logic        irqSet;
  logic        tick;
  logic        unusedData;

  // A write on the same edge swallows the pending step event.
  assign tick = (pre == PRE_LAST) && !iW_frame;
  assign unusedData = ^iFrame_data[5:0];

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      pre <= '0;
    end else if (iW_frame || tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 16'd1;
    end
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      step   <= S0;
      mode   <= 1'b0;
      envClk <= 1'b0;
      lenClk <= 1'b0;
    end else begin
      step   <= stepNext;
      envClk <= envNext;
      lenClk <= lenNext;
      if (iW_frame) begin
        mode <= iFrame_data[7];
      end
    end
  end

  always_comb begin
    stepNext = step;
    envNext  = 1'b0;
    lenNext  = 1'b0;
    irqSet   = 1'b0;
    unique case (1'b1)
      iW_frame: begin
        stepNext = S0;
        envNext  = iFrame_data[7];
        lenNext  = iFrame_data[7];
      end
      tick: begin
        case (step)
          S0: begin
            envNext  = 1'b1;
            stepNext = S1;
          end
          S1: begin
            envNext  = 1'b1;
            lenNext  = 1'b1;
            stepNext = S2;
          end
          S2: begin
            envNext  = 1'b1;
            stepNext = S3;
          end
          S3: begin
            // 5-step mode idles on this step
            envNext  = !mode;
            lenNext  = !mode;
            irqSet   = !mode;
            stepNext = mode ? S4 : S0;
          end
          S4: begin
            envNext  = 1'b1;
            lenNext  = 1'b1;
            stepNext = S0;
          end
          default: stepNext = S0;
        endcase
      end
      default: ;
    endcase
  end

`ifdef APU_FRAME_IRQ_EN
  logic inhibit;
  logic irq;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      inhibit <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (iW_frame) begin
        inhibit <= iFrame_data[6];
      end
      // setting beats a coincident ack
      if (irqSet && !inhibit) begin
        irq <= 1'b1;
      end else if (iIrq_ack || (iW_frame && iFrame_data[6])) begin
        irq <= 1'b0;
      end
    end
  end

  assign oIrq = irq;
`else
  logic unusedIrq;
  assign unusedIrq = ^{iIrq_ack, iFrame_data[6], irqSet};
  assign oIrq = 1'b0;
`endif

  assign oEnvelope_clk     = envClk;
  assign oLength_sweep_clk = lenClk;
  assign oStep             = step;
  assign oMode             = mode;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Bench for apu_frame_sequencer with DIVIDER=4.
// Reference model derives strobes from elapsed cycles and step tables.
module tb_apu_frame_sequencer;

  localparam int DIV = 4;
`ifdef APU_FRAME_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       iClk = 1'b0;
  logic       iReset = 1'b1;
  logic       iW_frame = 1'b0;
  logic [7:0] iFrame_data = 8'h00;
  logic       iIrq_ack = 1'b0;
  logic       oEnvelope_clk;
  logic       oLength_sweep_clk;
  logic       oIrq;
  logic [2:0] oStep;
  logic       oMode;

  apu_frame_sequencer #(.DIVIDER(DIV)) dut (
    .iClk(iClk),
    .iReset(iReset),
    .iW_frame(iW_frame),
    .iFrame_data(iFrame_data),
    .iIrq_ack(iIrq_ack),
    .oEnvelope_clk(oEnvelope_clk),
    .oLength_sweep_clk(oLength_sweep_clk),
    .oIrq(oIrq),
    .oStep(oStep),
    .oMode(oMode)
  );

  always #5 iClk = ~iClk;

  int compared = 0;
  int mismatched = 0;

  int sinceRestart;
  int mStep;
  bit mMode, mInh, mIrq, mEnv, mLen;
  int envPat[2][5] = '{'{1, 1, 1, 1, 0}, '{1, 1, 1, 0, 1}};
  int lenPat[2][5] = '{'{0, 1, 0, 1, 0}, '{0, 1, 0, 0, 1}};

  logic [6:0] dutVec;
  assign dutVec = {oEnvelope_clk, oLength_sweep_clk, oIrq, oStep, oMode};

  function automatic int seqLen(bit m);
    return m ? 5 : 4;
  endfunction

  function automatic logic [6:0] expVec();
    return {mEnv, mLen, mIrq, 3'(mStep), mMode};
  endfunction

  function automatic bit nextIsStep3();
    int n;
    n = sinceRestart + 1;
    return (n % DIV == 0) && (((n / DIV - 1) % seqLen(mMode)) == 3);
  endfunction

  task automatic modelReset();
    sinceRestart = 0;
    mStep = 0;
    mMode = 0;
    mInh = 0;
    mIrq = 0;
    mEnv = 0;
    mLen = 0;
  endtask

  task automatic cyc(input bit w, input logic [7:0] d, input bit ack);
    int k;
    int idx;
    iW_frame = w;
    iFrame_data = d;
    iIrq_ack = ack;
    @(posedge iClk);
    if (w) begin
      sinceRestart = 0;
      mMode = d[7];
      mEnv = d[7];
      mLen = d[7];
      mStep = 0;
      if (IRQ_EN) begin
        mInh = d[6];
        if (d[6] || ack) mIrq = 0;
      end
    end else begin
      sinceRestart++;
      mEnv = 0;
      mLen = 0;
      if (sinceRestart % DIV == 0) begin
        k = sinceRestart / DIV - 1;
        idx = k % seqLen(mMode);
        mEnv = envPat[mMode][idx] != 0;
        mLen = lenPat[mMode][idx] != 0;
        mStep = (idx + 1) % seqLen(mMode);
        if (IRQ_EN && !mMode && idx == 3 && !mInh) mIrq = 1;
        else if (ack) mIrq = 0;
      end else if (ack) begin
        mIrq = 0;
      end
    end
    #1;
    iW_frame = 1'b0;
    iIrq_ack = 1'b0;
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    #2;
    compared++;
    if (dutVec !== 7'd0) begin
      mismatched++;
      $display("FAIL reset: got %b want %b", dutVec, 7'd0);
    end
    #6;
    iReset = 1'b0;
    modelReset();
  endtask

  task automatic test_four_step();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      compared++;
      if (dutVec !== expVec()) begin
        mismatched++;
        $display("FAIL four_step c%0d: got %b want %b", i, dutVec, expVec());
      end
    end
  endtask

  task automatic test_irq_ack();
    cyc(1'b0, 8'h00, 1'b1);
    compared++;
    if (dutVec !== expVec()) begin
      mismatched++;
      $display("FAIL irq_ack: got %b want %b", dutVec, expVec());
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, nextIsStep3());
      compared++;
      if (dutVec !== expVec()) begin
        mismatched++;
        $display("FAIL irq_ack_coinc c%0d: got %b want %b", i, dutVec, expVec());
      end
    end
  endtask

  task automatic test_five_step();
    cyc(1'b1, 8'h80, 1'b0);
    compared++;
    if (dutVec !== {1'b1, 1'b1, mIrq, 3'd0, 1'b1}) begin
      mismatched++;
      $display("FAIL five_write: got %b want %b", dutVec, {1'b1, 1'b1, mIrq, 3'd0, 1'b1});
    end
    for (int i = 0; i < 24; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      compared++;
      if (dutVec !== expVec()) begin
        mismatched++;
        $display("FAIL five_step c%0d: got %b want %b", i, dutVec, expVec());
      end
    end
  endtask

  task automatic test_inhibit();
    cyc(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b0);
    compared++;
    if (oIrq !== IRQ_EN) begin
      mismatched++;
      $display("FAIL inhibit_pre: got %b want %b", oIrq, IRQ_EN);
    end
    cyc(1'b1, 8'h40, 1'b0);
    for (int i = 0; i < 3 * 4 * DIV; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      compared++;
      if (dutVec !== expVec() || oIrq !== 1'b0) begin
        mismatched++;
        $display("FAIL inhibit c%0d: got %b want %b", i, dutVec, expVec());
      end
    end
  endtask

  task automatic test_write_collision();
    cyc(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < DIV - 1; i++) cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h00, 1'b0);
    compared++;
    if ({oEnvelope_clk, oLength_sweep_clk, oStep} !== 5'd0) begin
      mismatched++;
      $display("FAIL collision: got %b want %b", {oEnvelope_clk, oLength_sweep_clk, oStep}, 5'd0);
    end
    for (int i = 0; i < DIV; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      compared++;
      if (dutVec !== expVec()) begin
        mismatched++;
        $display("FAIL collision_next c%0d: got %b want %b", i, dutVec, expVec());
      end
    end
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 16 + 2 * DIV + 2; i++) cyc(1'b0, 8'h00, 1'b0);
    compared++;
    if (dutVec !== expVec() || oStep !== 3'd2) begin
      mismatched++;
      $display("FAIL areset_pre: got %b want %b", dutVec, expVec());
    end
    #2;
    iReset = 1'b1;
    #1;
    compared++;
    if (dutVec !== 7'd0) begin
      mismatched++;
      $display("FAIL areset: got %b want %b", dutVec, 7'd0);
    end
    #3;
    iReset = 1'b0;
    modelReset();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      compared++;
      if (dutVec !== expVec()) begin
        mismatched++;
        $display("FAIL areset_seq c%0d: got %b want %b", i, dutVec, expVec());
      end
    end
  endtask

  task automatic test_random();
    bit w;
    bit ack;
    logic [7:0] d;
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 19) == 0);
      ack = ($urandom_range(0, 7) == 0);
      d = 8'($urandom);
      cyc(w, d, ack);
      compared++;
      if (dutVec !== expVec()) begin
        mismatched++;
        $display("FAIL random c%0d: got %b want %b", i, dutVec, expVec());
      end
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_four_step();
    test_irq_ack();
    test_five_step();
    test_inhibit();
    test_write_collision();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
